// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register scheduler.
// Covers PHY register addresses, the fixed init table and the scheduler state encoding.
package ulpi_pkg;

    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] IFC_CTRL  = 6'h07;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;

    localparam int INIT_LEN = 3;

    typedef struct packed {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] data;
    } init_entry_t;

    typedef enum logic [2:0] {
        S_WAIT_READY,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    // For a read entry, data holds the value expected back from the PHY.
    function automatic init_entry_t init_entry(input logic [1:0] idx);
        init_entry_t e;
        case (idx)
            2'd0:    e = '{rw: 1'b0, addr: OTG_CTRL,  data: 8'h00};
            2'd1:    e = '{rw: 1'b0, addr: FUNC_CTRL, data: 8'h45};
            default: e = '{rw: 1'b1, addr: FUNC_CTRL, data: 8'h45};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ulpi_reg_sched.sv
// Sole owner of the ULPI PHY register port.
// Runs the PHY init sequence, then arbitrates requesters A/B round-robin with timeout and retry.
module ulpi_reg_sched
    import ulpi_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1023,
    parameter int TO_W      = 10
) (
    input  logic       CLK_60M,
    input  logic       RST,
    input  logic       ULPI_READY,
    output logic       ULPI_REG_EN,
    output logic       ULPI_REG_RW,
    output logic [5:0] ULPI_REG_ADDR,
    output logic [7:0] ULPI_REG_WDATA,
    input  logic [7:0] ULPI_REG_RDATA,
    input  logic       ULPI_REG_DONE,
    input  logic       ULPI_REG_FAIL,
    input  logic       A_REQ,
    input  logic       A_RW,
    input  logic [5:0] A_ADDR,
    input  logic [7:0] A_WDATA,
    output logic       A_ACK,
    output logic       A_ERR,
    input  logic       B_REQ,
    input  logic       B_RW,
    input  logic [5:0] B_ADDR,
    input  logic [7:0] B_WDATA,
    output logic       B_ACK,
    output logic       B_ERR,
    output logic [7:0] RDATA,
    output logic       INIT_DONE,
    output logic       INIT_ERR,
    output logic       BUSY
);

    localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t            state;
    logic [1:0]        init_idx;
    logic [RT_W-1:0]   retry_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              ptr_b;
    logic              gnt_b;
    logic              retry_pend;

    init_entry_t       cur_entry;
    logic              timed_out;
    logic              retry_ok;
    logic              last_entry;
    logic              pick_b;

    assign cur_entry  = init_entry(init_idx);
    assign timed_out  = (to_cnt == TO_W'(TIMEOUT));
    assign retry_ok   = (retry_cnt < RT_W'(MAX_RETRY));
    assign last_entry = (init_idx == 2'(INIT_LEN - 1));

    // Under contention the side opposite the pointer wins.
    always_comb begin
        pick_b = B_REQ;
        if (A_REQ && B_REQ) begin
            pick_b = !ptr_b;
        end
    end

    always_ff @(posedge CLK_60M) begin
        if (RST) begin
            state          <= S_WAIT_READY;
            init_idx       <= 2'd0;
            retry_cnt      <= '0;
            to_cnt         <= '0;
            ptr_b          <= 1'b0;
            gnt_b          <= 1'b0;
            retry_pend     <= 1'b0;
            ULPI_REG_EN    <= 1'b0;
            ULPI_REG_RW    <= 1'b0;
            ULPI_REG_ADDR  <= 6'd0;
            ULPI_REG_WDATA <= 8'd0;
            A_ACK          <= 1'b0;
            A_ERR          <= 1'b0;
            B_ACK          <= 1'b0;
            B_ERR          <= 1'b0;
            RDATA          <= 8'd0;
            INIT_DONE      <= 1'b0;
            INIT_ERR       <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            A_ACK <= 1'b0;
            A_ERR <= 1'b0;
            B_ACK <= 1'b0;
            B_ERR <= 1'b0;

            case (state)
                S_WAIT_READY: begin
                    if (ULPI_READY) begin
                        init_idx  <= 2'd0;
                        retry_cnt <= '0;
                        state     <= S_INIT_ISSUE;
                    end
                end

                // EN is registered here, so this cycle doubles as the low gap before each init attempt.
                S_INIT_ISSUE: begin
                    ULPI_REG_EN    <= 1'b1;
                    ULPI_REG_RW    <= cur_entry.rw;
                    ULPI_REG_ADDR  <= cur_entry.addr;
                    ULPI_REG_WDATA <= cur_entry.rw ? 8'd0 : cur_entry.data;
                    BUSY           <= 1'b1;
                    to_cnt         <= '0;
                    state          <= S_INIT_WAIT;
                end

                S_INIT_WAIT: begin
                    if (ULPI_REG_DONE || ULPI_REG_FAIL || timed_out) begin
                        ULPI_REG_EN <= 1'b0;
                        BUSY        <= 1'b0;
                        if (!ULPI_REG_DONE && retry_ok) begin
                            retry_cnt <= retry_cnt + RT_W'(1);
                            state     <= S_INIT_ISSUE;
                        end else begin
                            retry_cnt <= '0;
                            if (!ULPI_REG_DONE || (cur_entry.rw && (ULPI_REG_RDATA != cur_entry.data))) begin
                                INIT_ERR <= 1'b1;
                            end
                            if (last_entry) begin
                                INIT_DONE <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                state    <= S_INIT_ISSUE;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_IDLE: begin
                    if (A_REQ || B_REQ) begin
                        gnt_b          <= pick_b;
                        if (A_REQ && B_REQ) begin
                            ptr_b <= pick_b;
                        end
                        ULPI_REG_RW    <= pick_b ? B_RW    : A_RW;
                        ULPI_REG_ADDR  <= pick_b ? B_ADDR  : A_ADDR;
                        ULPI_REG_WDATA <= pick_b ? B_WDATA : A_WDATA;
                        ULPI_REG_EN    <= 1'b1;
                        BUSY           <= 1'b1;
                        to_cnt         <= '0;
                        retry_cnt      <= '0;
                        state          <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (ULPI_REG_DONE) begin
                        ULPI_REG_EN <= 1'b0;
                        retry_pend  <= 1'b0;
                        A_ACK       <= !gnt_b;
                        B_ACK       <= gnt_b;
                        if (ULPI_REG_RW) begin
                            RDATA <= ULPI_REG_RDATA;
                        end
                        state <= S_GAP;
                    end else if (ULPI_REG_FAIL || timed_out) begin
                        ULPI_REG_EN <= 1'b0;
                        state       <= S_GAP;
                        if (retry_ok) begin
                            retry_cnt  <= retry_cnt + RT_W'(1);
                            retry_pend <= 1'b1;
                        end else begin
                            retry_pend <= 1'b0;
                            A_ERR      <= !gnt_b;
                            B_ERR      <= gnt_b;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                // A pending retry re-issues the latched access; otherwise the port is released.
                S_GAP: begin
                    if (retry_pend) begin
                        retry_pend  <= 1'b0;
                        ULPI_REG_EN <= 1'b1;
                        to_cnt      <= '0;
                        state       <= S_ISSUE;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_WAIT_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_reg_sched.sv
// Self-checking bench for ulpi_reg_sched: PHY model, access/response scoreboards and a vector table.
module tb_ulpi_reg_sched;

    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 1023;
    localparam int PHY_LAT   = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic       en;
    logic       reg_rw;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_done;
    logic       reg_fail;
    logic       a_req, a_rw, a_ack, a_err;
    logic [5:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req, b_rw, b_ack, b_err;
    logic [5:0] b_addr;
    logic [7:0] b_wdata;
    logic [7:0] rdata;
    logic       init_done, init_err, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] wdata;
    } phy_acc_t;

    typedef struct {
        logic       side_b;
        logic       err;
        logic       rd;
        logic [7:0] rdata;
    } resp_t;

    typedef struct {
        logic       a_req;
        logic       b_req;
        logic       a_rw;
        logic [5:0] a_addr;
        logic [7:0] a_wdata;
        logic       b_rw;
        logic [5:0] b_addr;
        logic [7:0] b_wdata;
        int         fails;
        logic       silent;
        logic [7:0] rresp;
        logic       exp_b;
        logic       exp_err;
    } vec_t;

    phy_acc_t phy_q[$];
    resp_t    resp_q[$];
    vec_t     vecs[7];

    int         fail_left = 0;
    logic       silent    = 1'b0;
    logic [7:0] rresp     = 8'h45;

    ulpi_reg_sched #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .TO_W(10)) dut (
        .CLK_60M        (clk),
        .RST            (rst),
        .ULPI_READY     (ready),
        .ULPI_REG_EN    (en),
        .ULPI_REG_RW    (reg_rw),
        .ULPI_REG_ADDR  (reg_addr),
        .ULPI_REG_WDATA (reg_wdata),
        .ULPI_REG_RDATA (reg_rdata),
        .ULPI_REG_DONE  (reg_done),
        .ULPI_REG_FAIL  (reg_fail),
        .A_REQ          (a_req),
        .A_RW           (a_rw),
        .A_ADDR         (a_addr),
        .A_WDATA        (a_wdata),
        .A_ACK          (a_ack),
        .A_ERR          (a_err),
        .B_REQ          (b_req),
        .B_RW           (b_rw),
        .B_ADDR         (b_addr),
        .B_WDATA        (b_wdata),
        .B_ACK          (b_ack),
        .B_ERR          (b_err),
        .RDATA          (rdata),
        .INIT_DONE      (init_done),
        .INIT_ERR       (init_err),
        .BUSY           (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_phy(input logic rw, input logic [5:0] addr, input logic [7:0] wdata);
        phy_acc_t p;
        p.rw = rw;
        p.addr = addr;
        p.wdata = wdata;
        phy_q.push_back(p);
    endtask

    task automatic push_init();
        push_phy(1'b0, 6'h0A, 8'h00);
        push_phy(1'b0, 6'h04, 8'h45);
        push_phy(1'b1, 6'h04, 8'h00);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output("init_done", init_done, 1);
    endtask

    // PHY model: answers each EN assertion after PHY_LAT cycles unless told to stay silent.
    initial begin
        int   cnt;
        logic en_prev;
        cnt = 0;
        en_prev = 1'b0;
        reg_done = 1'b0;
        reg_fail = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            reg_done = 1'b0;
            reg_fail = 1'b0;
            if (en === 1'b1) begin
                cnt = en_prev ? cnt + 1 : 1;
                if (!silent && cnt == PHY_LAT) begin
                    if (fail_left > 0) begin
                        reg_fail = 1'b1;
                        fail_left--;
                    end else begin
                        reg_done = 1'b1;
                        reg_rdata = reg_rw ? rresp : 8'h00;
                    end
                end
            end
            en_prev = (en === 1'b1);
        end
    end

    // Access scoreboard: every EN rise must match the next expected access and hold steady.
    initial begin
        logic     prev;
        logic     unstable;
        phy_acc_t got;
        phy_acc_t e;
        prev = 1'b0;
        unstable = 1'b0;
        got = '{1'b0, 6'd0, 8'd0};
        forever begin
            @(negedge clk);
            if (en === 1'b1 && !prev) begin
                got.rw = reg_rw;
                got.addr = reg_addr;
                got.wdata = reg_wdata;
                unstable = 1'b0;
                tests++;
                if (phy_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL phy_access: unexpected EN rise addr=0x%0h, expected none", reg_addr);
                end else begin
                    e = phy_q.pop_front();
                    if (got.rw !== e.rw || got.addr !== e.addr || (!e.rw && got.wdata !== e.wdata)) begin
                        fails++;
                        $display("[TB] FAIL phy_access: got rw=%0b addr=0x%0h wdata=0x%0h, expected rw=%0b addr=0x%0h wdata=0x%0h",
                                 got.rw, got.addr, got.wdata, e.rw, e.addr, e.wdata);
                    end
                end
            end else if (en === 1'b1 && prev) begin
                if (reg_rw !== got.rw || reg_addr !== got.addr || reg_wdata !== got.wdata) unstable = 1'b1;
            end else if (prev) begin
                check_output("en_stable", unstable, 0);
            end
            prev = (en === 1'b1);
        end
    end

    // Response scoreboard: each ACK/ERR pulse must match the next expected completion.
    initial begin
        resp_t e;
        int    np;
        forever begin
            @(negedge clk);
            np = 0;
            if (a_ack === 1'b1) np++;
            if (a_err === 1'b1) np++;
            if (b_ack === 1'b1) np++;
            if (b_err === 1'b1) np++;
            if (np > 0) begin
                tests++;
                if (np > 1 || resp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL resp_pulse: got ack/err a=%0b/%0b b=%0b/%0b, expected none", a_ack, a_err, b_ack, b_err);
                end else begin
                    e = resp_q.pop_front();
                    if ((b_ack | b_err) !== e.side_b || (a_err | b_err) !== e.err || (e.rd && rdata !== e.rdata)) begin
                        fails++;
                        $display("[TB] FAIL resp_pulse: got side_b=%0b err=%0b rdata=0x%0h, expected side_b=%0b err=%0b rdata=0x%0h",
                                 b_ack | b_err, a_err | b_err, rdata, e.side_b, e.err, e.rdata);
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input vec_t v);
        resp_t r;
        int    attempts;
        int    n;
        logic  got;
        fail_left = v.fails;
        silent = v.silent;
        rresp = v.rresp;
        attempts = v.silent ? MAX_RETRY + 1 : v.fails + 1;
        for (int k = 0; k < attempts; k++) begin
            if (v.exp_b) push_phy(v.b_rw, v.b_addr, v.b_wdata);
            else         push_phy(v.a_rw, v.a_addr, v.a_wdata);
        end
        r.side_b = v.exp_b;
        r.err = v.exp_err;
        r.rd = !v.exp_err && (v.exp_b ? v.b_rw : v.a_rw);
        r.rdata = v.rresp;
        resp_q.push_back(r);
        @(negedge clk);
        a_rw = v.a_rw; a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_rw = v.b_rw; b_addr = v.b_addr; b_wdata = v.b_wdata;
        a_req = v.a_req;
        b_req = v.b_req;
        n = 0;
        got = 1'b0;
        while (!got && n < 6000) begin
            @(negedge clk);
            n++;
            got = a_ack | a_err | b_ack | b_err;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check_output("resp_wait", got, 1);
        repeat (3) @(negedge clk);
        check_output("busy_idle", busy, 0);
        check_output("phy_q_drained", phy_q.size(), 0);
    endtask

    initial begin
        int   n;
        logic en_seen;

        //            a_req b_req a_rw a_addr a_wdata b_rw b_addr b_wdata fails silent rresp  exp_b exp_err
        vecs[0] = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h0A, 8'h00, 0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 6'h07, 8'h11, 1'b0, 6'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 6'h07, 8'h21, 1'b0, 6'h16, 8'h42, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 6'h07, 8'h22, 1'b0, 6'h16, 8'h43, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 6'h07, 8'h23, 1'b0, 6'h16, 8'h44, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 6'h16, 8'h00, 2, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 6'h0A, 8'h7E, 1'b0, 6'h00, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b1};

        rst = 1'b1; ready = 1'b0;
        a_req = 1'b0; a_rw = 1'b0; a_addr = 6'd0; a_wdata = 8'd0;
        b_req = 1'b0; b_rw = 1'b0; b_addr = 6'd0; b_wdata = 8'd0;
        repeat (3) @(negedge clk);
        check_output("reset_outputs",
                     {1'b0, en, reg_rw, reg_addr, reg_wdata, a_ack, a_err, b_ack, b_err, rdata, init_done, init_err, busy}, 0);
        rst = 1'b0;

        en_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (en !== 1'b0) en_seen = 1'b1;
        end
        check_output("no_en_before_ready", en_seen, 0);
        check_output("init_done_before_ready", init_done, 0);

        push_init();
        rresp = 8'h45;
        ready = 1'b1;
        wait_init();
        check_output("init_err_good_readback", init_err, 0);
        check_output("init_phy_q_drained", phy_q.size(), 0);
        repeat (2) @(negedge clk);
        check_output("busy_after_init", busy, 0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
        end
        check_output("rdata_held_after_err", rdata, 8'h5A);

        // Reset in the middle of an access, then rerun init with a bad readback.
        silent = 1'b1;
        push_phy(1'b0, 6'h07, 8'h33);
        a_rw = 1'b0; a_addr = 6'h07; a_wdata = 8'h33;
        a_req = 1'b1;
        n = 0;
        while (en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("en_raise_before_reset", en, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        a_req = 1'b0;
        @(negedge clk);
        check_output("en_drop_on_reset", en, 0);
        silent = 1'b0;
        rresp = 8'h41;
        @(negedge clk);
        check_output("reset_clears_init", {init_done, init_err, busy}, 0);
        push_init();
        rst = 1'b0;
        wait_init();
        check_output("init_err_bad_readback", init_err, 1);
        check_output("rerun_phy_q_drained", phy_q.size(), 0);

        apply_stimulus(vecs[1]);
        check_output("resp_q_drained", resp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_sched.md
Name: ulpi_reg_sched

Overview:
ulpi_reg_sched is the single owner of the ULPI block's PHY register access port, in the CLK_60M domain.
- After reset it waits for the PHY to be ready.
- It then plays a fixed PHY configuration sequence: OTG control, function control, readback check.
- It then shares the register port round-robin between two requesters (A: link/enumeration logic, B: debug/LED logic).
- It adds per-access timeout and bounded retry.

Parameters:
MAX_RETRY, 3, extra attempts after a failed or timed-out access (total attempts = MAX_RETRY+1)
TIMEOUT, 1023, cycles to wait for ULPI_REG_DONE/ULPI_REG_FAIL before declaring timeout
TO_W, 10, width of the timeout counter; must hold TIMEOUT

Ports:
CLK_60M  in  1  ULPI PHY clock; only clock
RST  in  1  synchronous, active-high reset
ULPI_READY  in  1  ULPI block idle and PHY out of reset
ULPI_REG_EN  out  1  register access request to ULPI
ULPI_REG_RW  out  1  1 = read, 0 = write
ULPI_REG_ADDR  out  6  PHY register address
ULPI_REG_WDATA  out  8  write data (drives ULPI REG_DATA_I)
ULPI_REG_RDATA  in  8  read data (from ULPI REG_DATA_O)
ULPI_REG_DONE  in  1  one-cycle pulse: access completed
ULPI_REG_FAIL  in  1  one-cycle pulse: access aborted (e.g. DIR turnaround)
A_REQ, B_REQ  in  1 each  requester access request; level, held until ACK/ERR
A_RW, B_RW  in  1 each  requester read/write select
A_ADDR, B_ADDR  in  6 each  requester address
A_WDATA, B_WDATA  in  8 each  requester write data
A_ACK, B_ACK  out  1 each  one-cycle pulse: access succeeded
A_ERR, B_ERR  out  1 each  one-cycle pulse: access failed after all retries
RDATA  out  8  read data; valid in the ACK cycle, held until the next completion
INIT_DONE  out  1  sticky: init sequence finished (successfully or not)
INIT_ERR  out  1  sticky: init access failed or readback mismatch
BUSY  out  1  an access is in flight

Behaviour:
Reset values:
- All outputs 0.
- State WAIT_READY, round-robin pointer = A, retry counter 0, timeout counter 0.
- RST mid-access drops ULPI_REG_EN in the next cycle; no ACK or ERR is issued.

Fixed init table (index: rw, addr, data):
- 0: write 0x0A, 0x00 (OTG control: pulldowns off)
- 1: write 0x04, 0x45 (function control: FS, TermSelect, SuspendM)
- 2: read 0x04, expect 0x45

State machine:
- WAIT_READY: wait for ULPI_READY=1, then go to INIT_ISSUE with index 0.
- INIT_ISSUE: present the table entry; ULPI_REG_EN=1; go to INIT_WAIT.
- INIT_WAIT:
  - On DONE: for a read, compare RDATA with the expected value and set INIT_ERR on mismatch. Advance the index; after index 2 set INIT_DONE and go to IDLE.
  - On FAIL or timeout: if retries remain, increment the retry count and go back to INIT_ISSUE. Otherwise set INIT_ERR and continue with the next entry.
- IDLE:
  - If exactly one REQ is high, grant it.
  - If both are high, grant the side opposite the pointer, then update the pointer to the granted side.
  - Latch the granted RW/ADDR/WDATA, then go to ISSUE.
- ISSUE: ULPI_REG_EN=1; go to WAIT.
- WAIT:
  - On DONE: pulse the granted ACK, load RDATA (reads only), go to GAP.
  - On FAIL or timeout: retry as in init. When exhausted, pulse the granted ERR and go to GAP.
- GAP: one cycle with ULPI_REG_EN=0, then go to IDLE.

Handshake and timing rules:
- ULPI_REG_EN rises in ISSUE and stays high through WAIT.
- RW/ADDR/WDATA are stable for the whole period EN is high.
- EN drops in the cycle after the DONE/FAIL/timeout decision.
- Each retry passes through a GAP cycle (EN low) before re-issue.
- DONE and FAIL in the same cycle: DONE wins.
- The timeout counter resets on every issue. Timeout fires when the counter reaches TIMEOUT with neither pulse seen.
- BUSY = 1 from ISSUE through GAP.
- Requests are ignored until INIT_DONE.
- A REQ dropped while granted is not aborted: the access completes and the ACK/ERR is still pulsed.
- Minimum latency, grant to ACK: 3 cycles + PHY time.

Decomposition:
- Package ulpi_pkg:
  - PHY register address constants (FUNC_CTRL=0x04, IFC_CTRL=0x07, OTG_CTRL=0x0A)
  - init table entry type {rw, addr, data} and INIT_LEN=3 table constant
  - state encoding
- No sub-module required. An optional two-requester round-robin arbiter, rr_arb2, can be factored out if reused.

Test Plan:
1. ULPI_READY held 0 for 50 cycles, then 1; PHY model answers DONE after 5 cycles with readback 0x45 -> writes 0x0A=0x00, 0x04=0x45, then read 0x04; INIT_DONE=1, INIT_ERR=0; no EN activity before READY.
2. Readback returns 0x41 -> INIT_DONE=1, INIT_ERR=1; requesters are still served afterwards.
3. A_REQ and B_REQ asserted together in the same cycle, three times (pointer starts at A) -> grants B, A, B; each requester sees exactly one ACK per access; EN low for ≥1 cycle between accesses.
4. Model pulses FAIL twice, then DONE on a B read of 0x16 returning 0x5A -> 3 EN assertions, B_ACK once, RDATA=0x5A, no B_ERR.
5. Model never responds to an A write -> 4 attempts, each timing out at 1023 cycles, then an A_ERR pulse; BUSY returns to 0.
6. RST asserted during WAIT -> EN=0 the next cycle, no ACK/ERR; after release the init sequence reruns from index 0.
